// File: rtl/or_stim_gen_pkg.sv
// Shared types and default constants for the OR-stage stimulus generator.
package or_stim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stim_state_e;

   localparam int STIM_WIDTH      = 2;
   localparam int STIM_TOGGLE_DIV = 3;
   localparam int STIM_RUN_LEN    = 20;

endpackage

// File: rtl/or_stim_gen_if.sv
// Operand bus between the stimulus generator and the OR stage, plus its controls.
// Handshake: start is a one-cycle request sampled on the rising edge; it is
// accepted only outside RUN, and valid/busy then stay high for the whole run.
interface or_stim_if #(
   parameter int WIDTH = 2
) ();
   logic             start;
   logic             force_en;
   logic [WIDTH-1:0] force_val;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output start, force_en, force_val,
      input  b, c, valid, busy, done
   );

   modport slave (
      input  start, force_en, force_val,
      output b, c, valid, busy, done
   );
endinterface

// File: rtl/or_stim_gen_div.sv
// Modulo-N tick counter; tick is high while the count sits at N-1.
module or_stim_div #(
   parameter int N = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick  = (cnt_q == LAST);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/or_stim_gen.sv
// Stimulus sequencer for the 2-bit OR stage: c toggles every TOGGLE_DIV run
// cycles, b steps once per full c period, and force_en overrides c at the output.
module or_stim_gen
   import or_stim_pkg::*;
#(
   parameter int WIDTH      = STIM_WIDTH,
   parameter int TOGGLE_DIV = STIM_TOGGLE_DIV,
   parameter int RUN_LEN    = STIM_RUN_LEN
) (
   input  logic        clk,
   input  logic        rst_n,
   or_stim_if.slave    ops_io,
   output stim_state_e state_o
);
   localparam int RW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
   localparam logic [RW-1:0] RUN_LAST = RW'(RUN_LEN - 1);

   generate
      if (WIDTH < 1 || TOGGLE_DIV < 1 || RUN_LEN < 1) begin : g_bad_params
         $fatal(1, "or_stim_gen: WIDTH, TOGGLE_DIV and RUN_LEN must all be >= 1");
      end
   endgenerate

   stim_state_e      state_q;
   logic [RW-1:0]    run_cnt_q;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             busy_q, done_q;
   logic             launch;
   logic             toggle;

   assign launch = ops_io.start && (state_q != RUN);
   // b advances only on the toggle that returns c to all-zeros (one full c period).
   assign c_d    = ~c_q;
   assign b_d    = (c_d == '0) ? b_q + WIDTH'(1) : b_q;

   or_stim_div #(.N(TOGGLE_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (launch),
      .en    (state_q == RUN),
      .tick  (toggle)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         run_cnt_q <= '0;
         b_q       <= '0;
         c_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (ops_io.start) begin
                  state_q   <= RUN;
                  run_cnt_q <= '0;
                  b_q       <= '0;
                  c_q       <= '0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
               end
            end
            RUN: begin
               run_cnt_q <= run_cnt_q + RW'(1);
               if (toggle) begin
                  c_q <= c_d;
                  b_q <= b_d;
               end
               if (run_cnt_q == RUN_LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ops_io.b     = b_q;
   assign ops_io.c     = ops_io.force_en ? ops_io.force_val : c_q;
   assign ops_io.valid = busy_q;
   assign ops_io.busy  = busy_q;
   assign ops_io.done  = done_q;
   assign state_o      = state_q;
endmodule

// File: tb/tb_or_stim_gen.sv
// Directed-plus-random bench for or_stim_gen with a toggle-count reference model.
module tb_or_stim_gen;
   import or_stim_pkg::*;

   localparam int W1 = 2, TD1 = 3, RL1 = 20;
   localparam int W2 = 1, TD2 = 1, RL2 = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   or_stim_if #(.WIDTH(W1)) if1 ();
   or_stim_if #(.WIDTH(W2)) if2 ();
   stim_state_e st1, st2;

   or_stim_gen #(.WIDTH(W1), .TOGGLE_DIV(TD1), .RUN_LEN(RL1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ops_io(if1.slave), .state_o(st1)
   );
   or_stim_gen #(.WIDTH(W2), .TOGGLE_DIV(TD2), .RUN_LEN(RL2)) dut2 (
      .clk(clk), .rst_n(rst_n), .ops_io(if2.slave), .state_o(st2)
   );

   // scoreboard
   int n_chk  = 0;
   int n_pass = 0;
   logic [1:0] exp_b_q[$];
   logic [1:0] exp_c_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // Reference: after k run cycles, toggles = floor(k/td); c is all-ones on odd
   // toggle counts, b is the number of completed c periods modulo 2^w.
   function automatic int n_toggles(input int k, input int td, input int rl);
      return ((k > rl) ? rl : k) / td;
   endfunction

   function automatic logic [1:0] mdl_c(input int k, input int td, input int rl, input int w);
      int t = n_toggles(k, td, rl);
      return (t % 2 == 1) ? 2'((1 << w) - 1) : 2'b00;
   endfunction

   function automatic logic [1:0] mdl_b(input int k, input int td, input int rl, input int w);
      int t = n_toggles(k, td, rl);
      return 2'((t / 2) % (1 << w));
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check1(input string nm, input int k, input bit forced, input logic [1:0] fv);
      logic [1:0] eb, ec;
      bit in_run;
      in_run = (k < RL1);
      eb = exp_b_q.pop_front();
      ec = exp_c_q.pop_front();
      chk($sformatf("%s k%0d state", nm, k), 32'(st1), in_run ? 32'(RUN) : 32'(DONE));
      chk($sformatf("%s k%0d busy", nm, k), 32'(if1.busy), 32'(in_run));
      chk($sformatf("%s k%0d valid", nm, k), 32'(if1.valid), 32'(in_run));
      chk($sformatf("%s k%0d done", nm, k), 32'(if1.done), 32'(!in_run));
      chk($sformatf("%s k%0d b", nm, k), 32'(if1.b), 32'(eb));
      chk($sformatf("%s k%0d c", nm, k), 32'(if1.c), forced ? 32'(fv) : 32'(ec));
   endtask

   task automatic check_zero1(input string nm);
      chk({nm, " state"}, 32'(st1), 32'(IDLE));
      chk({nm, " b"}, 32'(if1.b), 32'd0);
      chk({nm, " c"}, 32'(if1.c), 32'd0);
      chk({nm, " valid"}, 32'(if1.valid), 32'd0);
      chk({nm, " busy"}, 32'(if1.busy), 32'd0);
      chk({nm, " done"}, 32'(if1.done), 32'd0);
   endtask

   // One sequence on dut1; force window [f_lo,f_hi], start re-pulsed before
   // cycle mid_k, and an asynchronous reset just after cycle abort_k (0 = none).
   task automatic run1(input string nm, input int f_lo, input int f_hi,
                       input logic [1:0] fv, input int mid_k, input int abort_k);
      exp_b_q.delete();
      exp_c_q.delete();
      for (int k = 0; k <= RL1 + 2; k++) begin
         exp_b_q.push_back(mdl_b(k, TD1, RL1, W1));
         exp_c_q.push_back(mdl_c(k, TD1, RL1, W1));
      end
      if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      check1(nm, 0, 1'b0, fv);
      for (int k = 1; k <= RL1 + 2; k++) begin
         if1.force_en  = (k >= f_lo && k <= f_hi);
         if1.force_val = fv;
         if1.start     = (k == mid_k);
         tick();
         if1.start = 1'b0;
         check1(nm, k, if1.force_en, fv);
         if (k == abort_k) begin
            if1.force_en = 1'b0;
            #2 rst_n = 1'b0;
            #1 check_zero1({nm, " async"});
            @(negedge clk);
            rst_n = 1'b1;
            tick();
            check_zero1({nm, " no_restart"});
            return;
         end
      end
      if1.force_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      if1.start = 1'b1; if1.force_en = 1'b0; if1.force_val = '0;
      if2.start = 1'b1; if2.force_en = 1'b0; if2.force_val = '0;
      tick(); tick(); tick();
      check_zero1("reset");
      chk("reset dut2 state", 32'(st2), 32'(IDLE));
      chk("reset dut2 b", 32'(if2.b), 32'd0);
      chk("reset dut2 done", 32'(if2.done), 32'd0);
      if1.start = 1'b0;
      if2.start = 1'b0;
      rst_n = 1'b1;
      tick();
      check_zero1("idle");

      run1("dflt", 0, -1, 2'b00, 0, 0);
      run1("force", 4, 9, 2'b01, 0, 0);
      run1("mid_start", 0, -1, 2'b00, 8, 0);
      run1("last_start", 0, -1, 2'b00, RL1, 0);
      repeat (3) begin
         int lo, hi, mk;
         logic [1:0] fv;
         lo = $urandom_range(1, RL1);
         hi = $urandom_range(lo, RL1 + 2);
         mk = $urandom_range(1, RL1);
         fv = 2'($urandom_range(0, 3));
         run1("rand", lo, hi, fv, mk, 0);
      end
      run1("abort", 0, -1, 2'b00, 0, 7);
      run1("post_rst", 0, -1, 2'b00, 0, 0);

      // corner instance: WIDTH=1, TOGGLE_DIV=1, RUN_LEN=4
      if2.start = 1'b1;
      tick();
      if2.start = 1'b0;
      for (int k = 0; k <= RL2 + 1; k++) begin
         if (k > 0) tick();
         chk($sformatf("corner k%0d busy", k), 32'(if2.busy), 32'(k < RL2));
         chk($sformatf("corner k%0d done", k), 32'(if2.done), 32'(k >= RL2));
         chk($sformatf("corner k%0d b", k), 32'(if2.b), 32'(mdl_b(k, TD2, RL2, W2)));
         chk($sformatf("corner k%0d c", k), 32'(if2.c), 32'(mdl_c(k, TD2, RL2, W2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
